// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM state type and the inverse S-box table
package aes_pkg;

  localparam int AES_BLOCK_BITS  = 128;
  localparam int AES_BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Indexed directly by the ciphertext byte value.
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_s_box.sv
// rtl/inv_s_box.sv - combinational single-byte AES inverse S-box lookup
module inv_s_box
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = INV_SBOX[din];

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// rtl/aes_inv_sub_bytes.sv - iterative InvSubBytes, BYTES_PER_CYCLE bytes per clock
// with a valid/ready output handshake held until accepted.
module aes_inv_sub_bytes
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_en,
  output logic                      i_ready,
  input  logic [AES_BLOCK_BITS-1:0] data_in,
  output logic [AES_BLOCK_BITS-1:0] data_out,
  output logic                      o_en,
  input  logic                      o_ready
);

  localparam int N          = AES_BLOCK_BYTES / BYTES_PER_CYCLE;
  localparam int CW         = (N > 1) ? $clog2(N) : 1;
  localparam int CHUNK_BITS = BYTES_PER_CYCLE * 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  if ((AES_BLOCK_BYTES % BYTES_PER_CYCLE) != 0) begin : g_bad_bpc
    $error("BYTES_PER_CYCLE must divide 16");
  end

  state_t                    state_q;
  state_t                    state_d;
  logic [CW-1:0]             cnt_q;
  logic [AES_BLOCK_BITS-1:0] work_q;
  logic [AES_BLOCK_BITS-1:0] work_next;
  logic [CHUNK_BITS-1:0]     chunk_in;
  logic [CHUNK_BITS-1:0]     chunk_sub;
  logic                      load;
  logic                      step;
  logic                      last;
  logic                      out_done;

  assign i_ready  = (state_q == IDLE);
  assign chunk_in = work_q[cnt_q*CHUNK_BITS +: CHUNK_BITS];

  for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_sbox
    inv_s_box u_inv_s_box (
      .din  (chunk_in[b*8 +: 8]),
      .dout (chunk_sub[b*8 +: 8])
    );
  end

  // Only the current chunk is replaced; the rest of the state passes through.
  always_comb begin
    work_next = work_q;
    work_next[cnt_q*CHUNK_BITS +: CHUNK_BITS] = chunk_sub;
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    step     = 1'b0;
    last     = 1'b0;
    out_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_en) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CNT_LAST) begin
          last    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (o_ready) begin
          out_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // cnt stops at its last value so it never wraps; the next load clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      work_q   <= '0;
      data_out <= '0;
      o_en     <= 1'b0;
    end else begin
      if (load) begin
        work_q <= data_in;
        cnt_q  <= '0;
      end else if (step) begin
        work_q <= work_next;
        if (!last) begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
      if (last) begin
        data_out <= work_next;
        o_en     <= 1'b1;
      end else if (out_done) begin
        o_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// tb/tb_aes_inv_sub_bytes.sv - directed self-checking bench for aes_inv_sub_bytes
// at BYTES_PER_CYCLE 4 (main), 1 and 16.
module tb_aes_inv_sub_bytes;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic         clk;
  logic         rst;
  logic [127:0] data_in;
  logic         en   [3];
  logic         rdy  [3];
  logic         irdy [3];
  logic         oen  [3];
  logic [127:0] dout [3];

  int errors = 0;
  int checks = 0;

  aes_inv_sub_bytes #(.BYTES_PER_CYCLE(4)) u_dut (
    .clk(clk), .rst(rst), .i_en(en[0]), .i_ready(irdy[0]), .data_in(data_in),
    .data_out(dout[0]), .o_en(oen[0]), .o_ready(rdy[0]));
  aes_inv_sub_bytes #(.BYTES_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_en(en[1]), .i_ready(irdy[1]), .data_in(data_in),
    .data_out(dout[1]), .o_en(oen[1]), .o_ready(rdy[1]));
  aes_inv_sub_bytes #(.BYTES_PER_CYCLE(16)) u_dut16 (
    .clk(clk), .rst(rst), .i_en(en[2]), .i_ready(irdy[2]), .data_in(data_in),
    .data_out(dout[2]), .o_en(oen[2]), .o_ready(rdy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input int idx, input logic [127:0] din);
    @(negedge clk);
    check("accept_ready", 128'(irdy[idx]), 128'(1'b1));
    data_in  = din;
    en[idx]  = 1'b1;
    @(posedge clk);
    #1;
    en[idx]  = 1'b0;
  endtask

  task automatic wait_out(input int idx, input int exp_lat);
    int lat = 0;
    while (oen[idx] !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 128'(lat), 128'(exp_lat));
  endtask

  task automatic handshake(input int idx);
    @(negedge clk);
    rdy[idx] = 1'b1;
    @(posedge clk);
    #1;
    rdy[idx] = 1'b0;
    check("oen_after_h", 128'(oen[idx]), 128'(1'b0));
    check("irdy_after_h", 128'(irdy[idx]), 128'(1'b1));
  endtask

  initial begin
    logic [127:0] v;
    logic [127:0] e;
    logic [127:0] rt;
    logic [127:0] got;
    logic [127:0] blk_in  [3];
    logic [127:0] blk_exp [3];
    int lats [3];
    lats[0] = 4; lats[1] = 16; lats[2] = 1;

    rst = 1'b1;
    data_in = '0;
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0;
      rdy[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", dout[0], 128'h0);
    check("rst_oen", 128'(oen[0]), 128'(1'b0));
    check("rst_irdy", 128'(irdy[0]), 128'(1'b1));
    @(negedge clk);
    rst = 1'b0;

    // All 0x63 with o_ready high: o_en pulses exactly at A+4, i_ready returns after A+5.
    rdy[0] = 1'b1;
    start(0, {16{8'h63}});
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("t1_oen_a%0d", k), 128'(oen[0]), 128'(k == 4));
      check($sformatf("t1_irdy_a%0d", k), 128'(irdy[0]), 128'(k == 5));
      if (k == 4) check("t1_dout", dout[0], 128'h0);
    end
    rdy[0] = 1'b0;

    // Mixed bytes, endpoints of the block.
    v = {16{8'h7c}}; v[7:0] = 8'h16; v[127:120] = 8'hed;
    e = {16{8'h01}}; e[7:0] = 8'hff; e[127:120] = 8'h53;
    start(0, v);
    wait_out(0, 4);
    check("t2_dout", dout[0], e);
    handshake(0);

    // Full 256-value sweep at every width, checked by forward S-box round trip.
    for (int idx = 0; idx < 3; idx++) begin
      for (int s = 0; s < 16; s++) begin
        for (int k = 0; k < 16; k++) v[k*8 +: 8] = 8'(s*16 + k);
        start(idx, v);
        wait_out(idx, lats[idx]);
        got = dout[idx];
        for (int k = 0; k < 16; k++) rt[k*8 +: 8] = SBOX[got[k*8 +: 8]];
        check($sformatf("sweep_bpc_idx%0d_s%0d", idx, s), rt, v);
        if (s == 0) check("sweep_byte00", 128'(got[7:0]), 128'(8'h52));
        handshake(idx);
      end
    end

    // Backpressure: new data pulsed on i_en while HOLD stalls.
    start(0, {16{8'h7c}});
    wait_out(0, 4);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      en[0] = ~en[0];
      data_in = {16{8'h63}};
      @(posedge clk);
      #1;
      check("bp_oen", 128'(oen[0]), 128'(1'b1));
      check("bp_dout", dout[0], {16{8'h01}});
      check("bp_irdy", 128'(irdy[0]), 128'(1'b0));
    end
    @(negedge clk);
    en[0] = 1'b1;
    rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    en[0] = 1'b0;
    rdy[0] = 1'b0;
    check("bp_oen_h", 128'(oen[0]), 128'(1'b0));
    check("bp_irdy_h", 128'(irdy[0]), 128'(1'b1));
    check("bp_dout_h", dout[0], {16{8'h01}});
    repeat (6) @(posedge clk);
    #1;
    check("bp_no_accept_oen", 128'(oen[0]), 128'(1'b0));
    check("bp_no_accept_irdy", 128'(irdy[0]), 128'(1'b1));

    // Asynchronous reset just after A+2.
    start(0, {16{8'h16}});
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_dout", dout[0], 128'h0);
    check("arst_oen", 128'(oen[0]), 128'(1'b0));
    check("arst_irdy", 128'(irdy[0]), 128'(1'b1));
    @(negedge clk);
    rst = 1'b0;
    start(0, {16{8'h63}});
    wait_out(0, 4);
    check("arst_fresh_dout", dout[0], 128'h0);
    handshake(0);

    // Back-to-back with i_en and o_ready held high: accepts at A, A+6, A+12.
    blk_in[0] = {16{8'h63}}; blk_exp[0] = {16{8'h00}};
    blk_in[1] = {16{8'h7c}}; blk_exp[1] = {16{8'h01}};
    blk_in[2] = {16{8'h00}}; blk_exp[2] = {16{8'h52}};
    @(negedge clk);
    data_in = blk_in[0];
    en[0] = 1'b1;
    rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_accept0", 128'(irdy[0]), 128'(1'b0));
    for (int c = 1; c <= 17; c++) begin
      if (c % 6 == 1 && c / 6 < 2) data_in = blk_in[c / 6 + 1];
      @(posedge clk);
      #1;
      if (c % 6 == 4) begin
        check($sformatf("b2b_oen%0d", c / 6), 128'(oen[0]), 128'(1'b1));
        check($sformatf("b2b_dout%0d", c / 6), dout[0], blk_exp[c / 6]);
      end
      if (c % 6 == 5) check($sformatf("b2b_irdy%0d", c / 6), 128'(irdy[0]), 128'(1'b1));
      if (c % 6 == 0) check($sformatf("b2b_accept%0d", c / 6), 128'(irdy[0]), 128'(1'b0));
    end
    en[0] = 1'b0;
    rdy[0] = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
